mem_arbiter: RTL and testbench

//  - Single owner of the 256x8 data memory port.
//  - Sweeps memory to INIT_VALUE after reset, since the memory array has no reset.
//  - Then shares the port between two requesters (0 = CPU datapath, 1 = loader/debug) using round-robin.
//  - Drives the memory's address, active-low write enable and write data from registers; returns registered read data.

---
 rtl/mem_arbiter.sv | 109 ++++++++++
 tb/tb_mem_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Owns the single 256x8 data memory port: clears it to INIT_VALUE after reset, then
// shares it round-robin between the CPU datapath (port 0) and the loader/debug port (port 1).
module mem_arbiter #(
    parameter int            AW         = 8,
    parameter int            DW         = 8,
    parameter logic [DW-1:0] INIT_VALUE = '0,
    parameter bit            CLEAR_EN   = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid,
    output logic          rid,
    output logic [DW-1:0] rdata,
    output logic          init_done,
    output logic [AW-1:0] mem_addr,
    output logic          mem_wen_n,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic {CLEAR, RUN} state_t;

    localparam logic [AW:0] LAST_ADDR = {1'b0, {AW{1'b1}}};

    state_t      state, state_next;
    logic [AW:0] clr_cnt;
    logic        last;
    logic        rd_pend;
    logic        rd_pend_id;

    always_comb begin
        state_next = state;
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        case (state)
            CLEAR: begin
                if (clr_cnt == LAST_ADDR)
                    state_next = RUN;
            end
            RUN: begin
                // On a tie the port that did not win last time goes first.
                if (req0 && (!req1 || last))
                    gnt0 = 1'b1;
                else if (req1)
                    gnt1 = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= CLEAR_EN ? CLEAR : RUN;
            clr_cnt    <= '0;
            last       <= 1'b1;
            mem_addr   <= '0;
            mem_wen_n  <= 1'b1;
            mem_wdata  <= '0;
            rvalid     <= 1'b0;
            rid        <= 1'b0;
            rdata      <= '0;
            init_done  <= 1'b0;
            rd_pend    <= 1'b0;
            rd_pend_id <= 1'b0;
        end else begin
            state     <= state_next;
            rvalid    <= rd_pend;
            rd_pend   <= 1'b0;
            mem_wen_n <= 1'b1;
            if (rd_pend) begin
                rdata <= mem_rdata;
                rid   <= rd_pend_id;
            end
            // The final clear write commits at the end of the first RUN cycle.
            if (state == RUN)
                init_done <= 1'b1;
            if (state == CLEAR) begin
                mem_addr  <= clr_cnt[AW-1:0];
                mem_wen_n <= 1'b0;
                mem_wdata <= INIT_VALUE;
                clr_cnt   <= clr_cnt + 1'b1;
            end else if (gnt0) begin
                mem_addr   <= addr0;
                mem_wen_n  <= ~we0;
                mem_wdata  <= wdata0;
                rd_pend    <= ~we0;
                rd_pend_id <= 1'b0;
                last       <= 1'b0;
            end else if (gnt1) begin
                mem_addr   <= addr1;
                mem_wen_n  <= ~we1;
                mem_wdata  <= wdata1;
                rd_pend    <= ~we1;
                rd_pend_id <= 1'b1;
                last       <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a plain memory array behind the port, plus a queue-based
// model of requests, round-robin grants, memory contents and expected read returns.
module tb_mem_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [7:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
    logic       gnt0, gnt1, rvalid, rid, init_done, mem_wen_n;
    logic [7:0] rdata, mem_addr, mem_wdata, mem_rdata;

    mem_arbiter #(.AW(8), .DW(8), .INIT_VALUE(8'hA5), .CLEAR_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid(rvalid), .rid(rid), .rdata(rdata),
        .init_done(init_done), .mem_addr(mem_addr), .mem_wen_n(mem_wen_n),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [256];
    always @(posedge clk) if (!mem_wen_n) mem[mem_addr] <= mem_wdata;
    assign mem_rdata = mem[mem_addr];

    typedef struct { logic we; logic [7:0] addr; logic [7:0] wdata; } op_t;
    typedef struct { int due; logic id; logic [7:0] data; } rd_t;

    op_t        q0[$], q1[$];
    op_t        cur0, cur1;
    bit         act0, act1;
    rd_t        rdq[$];
    logic [7:0] ref_mem [256];
    logic       ref_last;
    bit         exp_init;
    int         cyc;
    int         checks = 0;
    int         errors = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic modelReset();
        foreach (ref_mem[i]) ref_mem[i] = 8'hA5;
        ref_last = 1'b1;
        exp_init = 1'b1;
        act0 = 0; act1 = 0;
        q0.delete(); q1.delete(); rdq.delete();
        cyc = 0;
    endtask

    // Idle ports get random address/data so a missing req qualification would show.
    task automatic applyStimulus();
        if (!act0 && q0.size() > 0) begin cur0 = q0.pop_front(); act0 = 1; end
        if (!act1 && q1.size() > 0) begin cur1 = q1.pop_front(); act1 = 1; end
        req0 = act0; we0 = act0 ? cur0.we : 1'($urandom);
        addr0 = act0 ? cur0.addr : 8'($urandom); wdata0 = act0 ? cur0.wdata : 8'($urandom);
        req1 = act1; we1 = act1 ? cur1.we : 1'($urandom);
        addr1 = act1 ? cur1.addr : 8'($urandom); wdata1 = act1 ? cur1.wdata : 8'($urandom);
    endtask

    task automatic stepCycle();
        bit  g0, g1, exp_rv;
        rd_t e;
        @(negedge clk);
        exp_rv = (rdq.size() > 0 && rdq[0].due == cyc);
        checkOutput("rvalid", rvalid, exp_rv);
        if (exp_rv) begin
            e = rdq.pop_front();
            checkOutput("rid", rid, e.id);
            checkOutput("rdata", rdata, e.data);
        end
        checkOutput("init_done", init_done, exp_init);
        applyStimulus();
        #1;
        if (act0 && act1) begin g0 = (ref_last == 1'b1); g1 = !g0; end
        else begin g0 = act0; g1 = act1; end
        checkOutput("gnt0", gnt0, g0);
        checkOutput("gnt1", gnt1, g1);
        if (g0) begin
            ref_last = 1'b0; act0 = 0;
            if (cur0.we) ref_mem[cur0.addr] = cur0.wdata;
            else rdq.push_back('{cyc + 2, 1'b0, ref_mem[cur0.addr]});
        end else if (g1) begin
            ref_last = 1'b1; act1 = 0;
            if (cur1.we) ref_mem[cur1.addr] = cur1.wdata;
            else rdq.push_back('{cyc + 2, 1'b1, ref_mem[cur1.addr]});
        end
        cyc++;
    endtask

    task automatic drain();
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || act0 || act1 || rdq.size() > 0) && n < 2000) begin
            stepCycle();
            n++;
        end
        checkOutput("drain_done", (n < 2000), 1);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_wen", mem_wen_n, 1);
        checkOutput("rst_addr", mem_addr, 0);
        checkOutput("rst_wdata", mem_wdata, 0);
        checkOutput("rst_rvalid", rvalid, 0);
        checkOutput("rst_rid", rid, 0);
        checkOutput("rst_rdata", rdata, 0);
        checkOutput("rst_init", init_done, 0);
        rst_n = 1'b1;
    endtask

    // Both ports request throughout the clear; they must not be granted while it runs.
    task automatic runSweep();
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h33;
        req1 = 1'b1; we1 = 1'b1; addr1 = 8'h44; wdata1 = 8'h99;
        for (int k = 1; k <= 256; k++) begin
            @(negedge clk);
            checkOutput("sweep_wen", mem_wen_n, 0);
            checkOutput("sweep_addr", mem_addr, k - 1);
            checkOutput("sweep_wdata", mem_wdata, 8'hA5);
            checkOutput("sweep_init", init_done, 0);
            checkOutput("sweep_rvalid", rvalid, 0);
            if (k < 256) begin
                checkOutput("sweep_gnt0", gnt0, 0);
                checkOutput("sweep_gnt1", gnt1, 0);
            end else begin
                req0 = 1'b0; req1 = 1'b0;
            end
        end
        modelReset();
    endtask

    task automatic randomTraffic(input int n);
        for (int i = 0; i < n; i++) begin
            if (q0.size() == 0 && !act0 && $urandom_range(0, 2) != 0)
                q0.push_back('{1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom)});
            if (q1.size() == 0 && !act1 && $urandom_range(0, 2) != 0)
                q1.push_back('{1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom)});
            stepCycle();
        end
        drain();
    endtask

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        cyc = 0;
        doReset();
        runSweep();

        // Contended reads straight after reset: port 0 first, then alternating.
        for (int i = 0; i < 3; i++) begin
            q0.push_back('{1'b0, 8'h01, 8'h00});
            q1.push_back('{1'b0, 8'h02, 8'h00});
        end
        drain();

        for (int a = 0; a < 256; a++) q1.push_back('{1'b0, 8'(a), 8'h00});
        drain();

        q0.push_back('{1'b1, 8'h10, 8'h3C});
        q0.push_back('{1'b0, 8'h10, 8'h00});
        drain();

        for (int a = 8'h20; a <= 8'h23; a++) q1.push_back('{1'b0, 8'(a), 8'h00});
        drain();

        q0.push_back('{1'b1, 8'h05, 8'hFF});
        q0.push_back('{1'b0, 8'h05, 8'h00});
        drain();

        randomTraffic(400);

        // Reset in the middle of a sweep must restart it from address 0.
        doReset();
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (mem_addr != 8'h80 && n < 300);
        checkOutput("midsweep_reach", (n < 300), 1);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("midrst_addr", mem_addr, 0);
        checkOutput("midrst_wen", mem_wen_n, 1);
        checkOutput("midrst_init", init_done, 0);
        rst_n = 1'b1;
        runSweep();

        q0.push_back('{1'b0, 8'h81, 8'h00});
        q1.push_back('{1'b0, 8'h10, 8'h00});
        drain();
        randomTraffic(200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
